// File: rtl/piece_drop_controller.sv
// piece_drop_controller: gravity/drop sequencer for the active tetromino.
// Owns XPOS/YPOS/currentBlock, issues one-cycle Enable requests to checkDown,
// advances the piece on a successful check and requests a board lock when the
// piece can no longer fall. A 4-bit LFSR (x^4+x^3+1) picks the next piece.
// Optional macro SOFT_DROP_EN adds the softDrop input and the softDropRows
// counter output.
module piece_drop_controller #(
    parameter logic [3:0] SPAWN_X   = 4'd6,
    parameter int         MAX_Y     = 16,
    parameter logic [3:0] LFSR_SEED = 4'b1001
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        Start,
    input  logic        Tick,
    input  logic        canMove,
    input  logic        lockAck,
`ifdef SOFT_DROP_EN
    input  logic        softDrop,
    output logic [15:0] softDropRows,
`endif
    output logic        Enable,
    output logic [3:0]  XPOS,
    output logic [4:0]  YPOS,
    output logic [1:0]  currentBlock,
    output logic        lockReq,
    output logic        gameOver,
    output logic [15:0] pieceCount
);

    typedef enum logic [3:0] {
        IDLE,
        SPAWN,
        SPAWN_CHK,
        SPAWN_EVAL,
        WAIT_TICK,
        CHECK,
        EVAL,
        LOCK,
        GAME_OVER
    } state_t;

    state_t     state;
    logic [3:0] lfsr;
    logic       tickPending;
    logic       gravity;

`ifdef SOFT_DROP_EN
    // set when the current check was launched by soft drop, so only those
    // steps count toward softDropRows
    logic softStep;
    assign gravity = Tick | tickPending | softDrop;
`else
    assign gravity = Tick | tickPending;
`endif

    // Sequencer: state, registered outputs, LFSR and the one-deep tick latch
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state        <= IDLE;
            Enable       <= 1'b0;
            lockReq      <= 1'b0;
            gameOver     <= 1'b0;
            XPOS         <= SPAWN_X;
            YPOS         <= 5'd0;
            currentBlock <= 2'b00;
            pieceCount   <= 16'd0;
            lfsr         <= LFSR_SEED;
            tickPending  <= 1'b0;
`ifdef SOFT_DROP_EN
            softDropRows <= 16'd0;
            softStep     <= 1'b0;
`endif
        end else begin
            // Enable is a single-cycle strobe, raised only on entry to a check state
            Enable <= 1'b0;

            // remember one tick that lands while the piece is busy; extras are dropped
            if (Tick && state != IDLE && state != WAIT_TICK && state != GAME_OVER)
                tickPending <= 1'b1;

            case (state)
                IDLE: begin
                    if (Start) begin
                        state       <= SPAWN;
                        pieceCount  <= 16'd0;
                        tickPending <= 1'b0;
`ifdef SOFT_DROP_EN
                        softDropRows <= 16'd0;
`endif
                    end
                end
                SPAWN: begin
                    YPOS         <= 5'd0;
                    XPOS         <= SPAWN_X;
                    currentBlock <= lfsr[1:0];
                    lfsr         <= {lfsr[2:0], lfsr[3] ^ lfsr[2]};
                    Enable       <= 1'b1;
                    state        <= SPAWN_CHK;
                end
                SPAWN_CHK: begin
                    state <= SPAWN_EVAL;
                end
                SPAWN_EVAL: begin
                    if (canMove) begin
                        state <= WAIT_TICK;
                    end else begin
                        gameOver <= 1'b1;
                        state    <= GAME_OVER;
                    end
                end
                WAIT_TICK: begin
                    if (gravity) begin
                        Enable      <= 1'b1;
                        tickPending <= 1'b0;
`ifdef SOFT_DROP_EN
                        softStep    <= softDrop;
`endif
                        state       <= CHECK;
                    end
                end
                CHECK: begin
                    state <= EVAL;
                end
                EVAL: begin
                    if (canMove) begin
                        // checkDown already refuses at MAX_Y; guard anyway so YPOS cannot pass it
                        if (YPOS < 5'(MAX_Y))
                            YPOS <= YPOS + 5'd1;
`ifdef SOFT_DROP_EN
                        if (softStep && softDropRows != 16'hFFFF)
                            softDropRows <= softDropRows + 16'd1;
`endif
                        state <= WAIT_TICK;
                    end else begin
                        lockReq <= 1'b1;
                        state   <= LOCK;
                    end
                end
                LOCK: begin
                    if (lockAck) begin
                        lockReq <= 1'b0;
                        if (pieceCount != 16'hFFFF)
                            pieceCount <= pieceCount + 16'd1;
                        state <= SPAWN;
                    end
                end
                GAME_OVER: begin
                    if (Start) begin
                        gameOver <= 1'b0;
`ifdef SOFT_DROP_EN
                        softDropRows <= 16'd0;
`endif
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_piece_drop_controller.sv
// tb_piece_drop_controller: directed test of the drop sequencer with a small
// checkDown stand-in (canMove registered from an allow flag and YPOS < 16).
module tb_piece_drop_controller;

    logic        Clock = 1'b0;
    logic        Reset, Start, Tick, canMove, lockAck;
    logic        Enable, lockReq, gameOver;
    logic [3:0]  XPOS;
    logic [4:0]  YPOS;
    logic [1:0]  currentBlock;
    logic [15:0] pieceCount;
`ifdef SOFT_DROP_EN
    logic        softDrop;
    logic [15:0] softDropRows;
`endif

    int checks = 0;
    int errors = 0;
    int en_cnt = 0;
    int en_dbl = 0;
    logic en_prev = 1'b0;
    logic allow = 1'b1;

    always #5 Clock = ~Clock;

    piece_drop_controller dut (
        .Clock(Clock), .Reset(Reset), .Start(Start), .Tick(Tick),
        .canMove(canMove), .lockAck(lockAck),
`ifdef SOFT_DROP_EN
        .softDrop(softDrop), .softDropRows(softDropRows),
`endif
        .Enable(Enable), .XPOS(XPOS), .YPOS(YPOS), .currentBlock(currentBlock),
        .lockReq(lockReq), .gameOver(gameOver), .pieceCount(pieceCount)
    );

    // checkDown stand-in: registered result, blocked at row 16
    always @(posedge Clock) canMove <= allow && (YPOS < 5'd16);

    // Enable pulse counting and back-to-back detection
    always @(negedge Clock) begin
        if (Enable) en_cnt++;
        if (Enable && en_prev) en_dbl++;
        en_prev = Enable;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    // Tick in WAIT_TICK: YPOS unchanged two edges later, updated on the third
    task automatic tick_y(input int y0, input int y1);
        Tick = 1'b1; step(); Tick = 1'b0;
        step(); chk("ypos_hold", 32'(YPOS), 32'(y0));
        step(); chk("ypos_step", 32'(YPOS), 32'(y1));
    endtask

    // Tick on a blocked move: lockReq rises on the third edge, piece stays put
    task automatic tick_lock(input int y);
        Tick = 1'b1; step(); Tick = 1'b0;
        step(); chk("lockreq_early", 32'(lockReq), 32'd0);
        step(); chk("lockreq_rise", 32'(lockReq), 32'd1);
        chk("lock_ypos", 32'(YPOS), 32'(y));
    endtask

    initial begin
        Reset = 1'b1; Start = 1'b0; Tick = 1'b0; lockAck = 1'b0;
`ifdef SOFT_DROP_EN
        softDrop = 1'b0;
`endif
        repeat (3) step();
        chk("rst_enable", 32'(Enable), 32'd0);
        chk("rst_lockreq", 32'(lockReq), 32'd0);
        chk("rst_gameover", 32'(gameOver), 32'd0);
        chk("rst_xpos", 32'(XPOS), 32'd6);
        chk("rst_ypos", 32'(YPOS), 32'd0);
        chk("rst_block", 32'(currentBlock), 32'd0);
        chk("rst_count", 32'(pieceCount), 32'd0);
        Reset = 1'b0;
        step();

        // start: one spawn check, first piece from seed 1001 -> 01
        en_cnt = 0;
        Start = 1'b1; step(); Start = 1'b0;
        repeat (10) step();
        chk("spawn1_block", 32'(currentBlock), 32'd1);
        chk("spawn1_xpos", 32'(XPOS), 32'd6);
        chk("spawn1_en", 32'(en_cnt), 32'd1);

        // five ticks spaced 10 cycles apart
        for (int i = 0; i < 5; i++) begin
            tick_y(i, i + 1);
            repeat (7) step();
        end
        chk("en_count6", 32'(en_cnt), 32'd6);
        tick_y(5, 6); step();
        tick_y(6, 7); step();

        // blocked at row 7 -> lock; two ticks during LOCK, ack 4 cycles later
        allow = 1'b0;
        tick_lock(7);
        Tick = 1'b1; step(); Tick = 1'b0; step();
        Tick = 1'b1; step(); Tick = 1'b0; step();
        chk("lockreq_held", 32'(lockReq), 32'd1);
        chk("lock_ypos_held", 32'(YPOS), 32'd7);
        en_cnt = 0;
        lockAck = 1'b1; allow = 1'b1; step(); lockAck = 1'b0;
        chk("ack_lockreq", 32'(lockReq), 32'd0);
        chk("ack_count", 32'(pieceCount), 32'd1);
        step();
        chk("spawn2_ypos", 32'(YPOS), 32'd0);
        chk("spawn2_xpos", 32'(XPOS), 32'd6);
        chk("spawn2_block", 32'(currentBlock), 32'd3);
        repeat (20) step();
        chk("pending_ypos", 32'(YPOS), 32'd1);
        chk("pending_en", 32'(en_cnt), 32'd2);

        // fall to the floor row 16, then the next check blocks
        for (int y = 1; y < 16; y++) begin
            tick_y(y, y + 1);
            step();
        end
        tick_lock(16);
        allow = 1'b0;
        lockAck = 1'b1; step(); lockAck = 1'b0;
        chk("ack2_count", 32'(pieceCount), 32'd2);

        // spawn blocked -> game over, nothing locked
        repeat (10) step();
        chk("go_flag", 32'(gameOver), 32'd1);
        chk("go_lockreq", 32'(lockReq), 32'd0);
        chk("go_count", 32'(pieceCount), 32'd2);
        chk("go_block", 32'(currentBlock), 32'd2);
        en_cnt = 0;
        Tick = 1'b1; step(); Tick = 1'b0;
        repeat (5) step();
        chk("go_tick_ignored", 32'(en_cnt), 32'd0);
        Start = 1'b1; step(); Start = 1'b0;
        chk("go_to_idle", 32'(gameOver), 32'd0);
        repeat (3) step();
        chk("idle_quiet", 32'(en_cnt), 32'd0);
        allow = 1'b1;
        Start = 1'b1; step(); Start = 1'b0;
        chk("restart_count", 32'(pieceCount), 32'd0);
        step();
        chk("restart_block", 32'(currentBlock), 32'd1);
        repeat (8) step();

        // lock one piece, then reset asynchronously mid-LOCK of the next
        allow = 1'b0;
        tick_lock(0);
        allow = 1'b1;
        lockAck = 1'b1; step(); lockAck = 1'b0;
        repeat (10) step();
        tick_y(0, 1); step();
        allow = 1'b0;
        tick_lock(1);
        chk("prereset_count", 32'(pieceCount), 32'd1);
        #2 Reset = 1'b1;
        #1;
        chk("async_lockreq", 32'(lockReq), 32'd0);
        chk("async_ypos", 32'(YPOS), 32'd0);
        chk("async_count", 32'(pieceCount), 32'd0);
        chk("async_xpos", 32'(XPOS), 32'd6);
        step(); Reset = 1'b0; allow = 1'b1;
        en_cnt = 0;
        Tick = 1'b1; step(); Tick = 1'b0;
        repeat (5) step();
        chk("idle_tick_ignored", 32'(en_cnt), 32'd0);

`ifdef SOFT_DROP_EN
        Start = 1'b1; step(); Start = 1'b0;
        repeat (10) step();
        softDrop = 1'b1;
        repeat (12) step();
        softDrop = 1'b0;
        chk("soft_ypos", 32'(YPOS), 32'd4);
        chk("soft_rows", 32'(softDropRows), 32'd4);
`endif

        chk("enable_single", 32'(en_dbl), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
